ifetch_queue: RTL and testbench

Instruction fetch stage with a prefetch buffer, sitting directly upstream of the cpu decode stage. It owns the program counter, issues word-addressed requests to instruction memory over a req/ack handshake that tolerates variable latency, and buffers returned instructions with their PCs in a DEPTH-entry FIFO. Decode drains the FIFO with a valid/ready handshake. A redirect from branch/jump resolution flushes the FIFO and restarts fetch.

---
 rtl/ifetch_queue.sv | 177 +++++++++++++++++
 tb/tb_ifetch_queue.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_queue.sv
// Instruction fetch stage: owns the PC, issues one-at-a-time imem requests and buffers
// {pc, inst} pairs in a DEPTH-entry FIFO for decode. Optional macro: IFQ_HLT_STOP_EN.
module ifetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       redirect,
  input  logic [15:0]                redirect_pc,
  output logic                       imem_req,
  output logic [15:0]                imem_addr,
  input  logic                       imem_ack,
  input  logic [15:0]                imem_data,
  output logic                       id_valid,
  output logic [15:0]                id_inst,
  output logic [15:0]                id_pc,
  input  logic                       id_ready,
  output logic [15:0]                fetch_pc,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic [1:0]                 state_dbg
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DROP = 2'd2, HALT = 2'd3} state_e;

  state_e        state_q, state_d;
  logic          req_q, req_d;
  logic [15:0]   addr_q, addr_d;
  logic [15:0]   pc_q, pc_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] occ_q, occ_d;
  logic [15:0]   inst_mem_q [DEPTH];
  logic [15:0]   inst_mem_d [DEPTH];
  logic [15:0]   pc_mem_q   [DEPTH];
  logic [15:0]   pc_mem_d   [DEPTH];

  logic          ack_kept;
  logic          push;
  logic          pop;
  logic          halt_hit;
  logic [CW-1:0] occ_after;
  logic          can_issue;

  // Handshakes: a request completes on a cycle with imem_req & imem_ack; an entry leaves
  // the FIFO on a cycle with id_valid & id_ready. Redirect overrides both in that cycle.
  assign ack_kept  = (state_q == WAIT) && imem_ack;
  assign push      = ack_kept && !redirect;
  assign pop       = (occ_q != '0) && id_ready;
  assign occ_after = occ_q + CW'(push) - CW'(pop);
  // Evaluated after this cycle's push/pop, so a newly issued request always has a slot.
  assign can_issue = occ_after < CW'(DEPTH);

`ifdef IFQ_HLT_STOP_EN
  assign halt_hit = push && (imem_data[15:12] == 4'hF);
`else
  assign halt_hit = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    addr_d     = addr_q;
    pc_d       = pc_q;
    rd_ptr_d   = rd_ptr_q + PW'(pop);
    wr_ptr_d   = wr_ptr_q + PW'(push);
    occ_d      = occ_after;
    inst_mem_d = inst_mem_q;
    pc_mem_d   = pc_mem_q;
    if (push) begin
      inst_mem_d[wr_ptr_q] = imem_data;
      pc_mem_d[wr_ptr_q]   = addr_q;
    end

    if (redirect) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      occ_d    = '0;
      pc_d     = redirect_pc;
      unique case (state_q)
        IDLE, HALT: begin
          req_d   = 1'b1;
          addr_d  = redirect_pc;
          state_d = WAIT;
        end
        WAIT: begin
          if (imem_ack) begin
            req_d   = 1'b0;
            state_d = IDLE;
          end else begin
            state_d = DROP;
          end
        end
        DROP: begin
          if (imem_ack) begin
            req_d   = 1'b0;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end else begin
      unique case (state_q)
        IDLE: begin
          if (can_issue) begin
            req_d   = 1'b1;
            addr_d  = pc_q;
            state_d = WAIT;
          end
        end
        WAIT: begin
          if (imem_ack) begin
            pc_d = addr_q + 16'd1;
            if (halt_hit) begin
              req_d   = 1'b0;
              state_d = HALT;
            end else if (can_issue) begin
              addr_d = addr_q + 16'd1;
            end else begin
              req_d   = 1'b0;
              state_d = IDLE;
            end
          end
        end
        DROP: begin
          if (imem_ack) begin
            req_d   = 1'b0;
            state_d = IDLE;
          end
        end
        HALT: begin
          req_d = 1'b0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      req_q    <= 1'b0;
      addr_q   <= RESET_PC;
      pc_q     <= RESET_PC;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        inst_mem_q[i] <= '0;
        pc_mem_q[i]   <= '0;
      end
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      pc_q       <= pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      occ_q      <= occ_d;
      inst_mem_q <= inst_mem_d;
      pc_mem_q   <= pc_mem_d;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign fetch_pc  = pc_q;
  assign occupancy = occ_q;
  assign id_valid  = (occ_q != '0);
  assign id_inst   = inst_mem_q[rd_ptr_q];
  assign id_pc     = pc_mem_q[rd_ptr_q];
  assign state_dbg = state_q;

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: behavioural imem responder, expected-stream scoreboard and
// scenario tasks run in sequence.
module tb_ifetch_queue;

  localparam int          DEPTH   = 4;
  localparam logic [1:0]  ST_IDLE = 2'd0;
  localparam logic [1:0]  ST_DROP = 2'd2;
  localparam logic [1:0]  ST_HALT = 2'd3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_data = 16'h0000;
  logic        id_valid;
  logic [15:0] id_inst;
  logic [15:0] id_pc;
  logic        id_ready = 1'b0;
  logic [15:0] fetch_pc;
  logic [2:0]  occupancy;
  logic [1:0]  state_dbg;

  int n_vec = 0;
  int n_err = 0;

  ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .id_valid(id_valid), .id_inst(id_inst), .id_pc(id_pc), .id_ready(id_ready),
    .fetch_pc(fetch_pc), .occupancy(occupancy), .state_dbg(state_dbg)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Instruction memory contents
  bit hlt_word_en = 1'b0;

  function automatic logic [15:0] word(input logic [15:0] a);
    if (hlt_word_en && a == 16'h0002) return 16'hF000;
    return {4'h1, a[11:0]};
  endfunction

  // Memory responder: latency counted in idle cycles of a request, driven on negedge
  int lat_cfg  = 0;
  bit rand_lat = 1'b0;
  int cur_lat  = 0;
  int wcnt     = 0;

  always @(negedge clk) begin
    if (rst || !imem_req) begin
      imem_ack = 1'b0;
      wcnt     = 0;
    end else if (wcnt >= (rand_lat ? cur_lat : lat_cfg)) begin
      imem_ack  = 1'b1;
      imem_data = word(imem_addr);
      wcnt      = 0;
      cur_lat   = $urandom_range(0, 3);
    end else begin
      imem_ack = 1'b0;
      wcnt++;
    end
  end

  // Scoreboard: expected {pc, inst} stream, sampled just before each rising edge
  logic [31:0] exp_q[$];
  logic [31:0] want;
  int          pop_cnt = 0;
  int          ack_cnt = 0;
  logic        open_q = 1'b0;
  logic [15:0] open_addr = 16'h0000;

  always @(negedge clk) begin
    #4;
    if (rst) begin
      open_q = 1'b0;
    end else begin
      if (open_q) begin
        n_vec++;
        if (imem_req !== 1'b1 || imem_addr !== open_addr) begin
          n_err++;
          $display("FAIL req_hold: req=%b addr=%h, required req=1 addr=%h", imem_req, imem_addr, open_addr);
        end
      end
      open_q    = imem_req && !imem_ack;
      open_addr = imem_addr;
      if (imem_req && imem_ack) ack_cnt++;
      if (id_valid && id_ready && !redirect) begin
        pop_cnt++;
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL sb_entry: got pc=%h inst=%h, required no entry", id_pc, id_inst);
        end else begin
          want = exp_q.pop_front();
          if ({id_pc, id_inst} !== want) begin
            n_err++;
            $display("FAIL sb_entry: got pc=%h inst=%h, required pc=%h inst=%h",
                     id_pc, id_inst, want[31:16], want[15:0]);
          end
        end
      end
    end
  end

  // Driver tasks
  task automatic fill_stream(input logic [15:0] start, input int n);
    logic [15:0] a;
    for (int i = 0; i < n; i++) begin
      a = start + 16'(i);
      exp_q.push_back({a, word(a)});
    end
  endtask

  // Returns at the negedge on which rst is released.
  task automatic do_reset(input int lat, input bit rnd, input bit rdy);
    @(negedge clk);
    rst      = 1'b1;
    redirect = 1'b0;
    id_ready = rdy;
    lat_cfg  = lat;
    rand_lat = rnd;
    cur_lat  = lat;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_redirect(input logic [15:0] pc);
    redirect    = 1'b1;
    redirect_pc = pc;
    exp_q.delete();
    fill_stream(pc, 512);
    @(negedge clk);
    redirect = 1'b0;
  endtask

  // Scenario tasks
  task automatic test_reset();
    do_reset(2, 1'b0, 1'b1);
    fill_stream(16'h0000, 64);
    repeat (5) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_vec++;
    if ({imem_req, imem_addr, fetch_pc} !== {1'b0, 16'h0000, 16'h0000}) begin
      n_err++;
      $display("FAIL reset_req: req=%b addr=%h fetch_pc=%h, required 0/0000/0000", imem_req, imem_addr, fetch_pc);
    end
    n_vec++;
    if ({id_valid, id_inst, id_pc, occupancy} !== {1'b0, 16'h0000, 16'h0000, 3'd0}) begin
      n_err++;
      $display("FAIL reset_fifo: valid=%b inst=%h pc=%h occ=%0d, required 0/0000/0000/0", id_valid, id_inst, id_pc, occupancy);
    end
    n_vec++;
    if (state_dbg !== ST_IDLE) begin
      n_err++;
      $display("FAIL reset_state: state=%0d, required %0d", state_dbg, ST_IDLE);
    end
    exp_q.delete();
    fill_stream(16'h0000, 64);
    @(negedge clk);
    rst = 1'b0;
    n_vec++;
    if (imem_req !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: req=%b, required 0", imem_req);
    end
    @(negedge clk);
    n_vec++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
      n_err++;
      $display("FAIL first_req: req=%b addr=%h, required 1/0000", imem_req, imem_addr);
    end
    repeat (12) @(negedge clk);
  endtask

  task automatic test_zero_wait();
    do_reset(0, 1'b0, 1'b1);
    fill_stream(16'h0000, 64);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++;
      if (id_valid !== 1'b1 || id_pc !== 16'(i) || id_inst !== 16'h1000 + 16'(i)) begin
        n_err++;
        $display("FAIL zw_head%0d: valid=%b pc=%h inst=%h, required 1/%h/%h", i, id_valid, id_pc, id_inst, 16'(i), 16'h1000 + 16'(i));
      end
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_vec++;
      if (id_valid !== 1'b1 || occupancy !== 3'd1) begin
        n_err++;
        $display("FAIL zw_stream: valid=%b occ=%0d, required 1/1", id_valid, occupancy);
      end
    end
  endtask

  task automatic test_backpressure();
    int a0;
    do_reset(0, 1'b0, 1'b0);
    fill_stream(16'h0000, 64);
    a0 = ack_cnt;
    repeat (10) @(negedge clk);
    n_vec++;
    if (occupancy !== 3'd4 || imem_req !== 1'b0 || ack_cnt - a0 != 4) begin
      n_err++;
      $display("FAIL bp_full: occ=%0d req=%b acks=%0d, required 4/0/4", occupancy, imem_req, ack_cnt - a0);
    end
    n_vec++;
    if (id_valid !== 1'b1 || id_pc !== 16'h0000 || fetch_pc !== 16'h0004) begin
      n_err++;
      $display("FAIL bp_head: valid=%b pc=%h fetch_pc=%h, required 1/0000/0004", id_valid, id_pc, fetch_pc);
    end
    id_ready = 1'b1;
    @(negedge clk);
    id_ready = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if (occupancy !== 3'd4 || imem_req !== 1'b0 || ack_cnt - a0 != 5) begin
      n_err++;
      $display("FAIL bp_one: occ=%0d req=%b acks=%0d, required 4/0/5", occupancy, imem_req, ack_cnt - a0);
    end
    n_vec++;
    if (id_pc !== 16'h0001 || id_inst !== 16'h1001 || fetch_pc !== 16'h0005) begin
      n_err++;
      $display("FAIL bp_next: pc=%h inst=%h fetch_pc=%h, required 0001/1001/0005", id_pc, id_inst, fetch_pc);
    end
  endtask

  // Runs from the full, idle state left by test_backpressure.
  task automatic test_redirect_idle();
    do_redirect(16'h0100);
    n_vec++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0100 || id_valid !== 1'b0 || occupancy !== 3'd0) begin
      n_err++;
      $display("FAIL redir_idle: req=%b addr=%h valid=%b occ=%0d, required 1/0100/0/0", imem_req, imem_addr, id_valid, occupancy);
    end
    @(negedge clk);
    n_vec++;
    if (id_valid !== 1'b1 || id_pc !== 16'h0100 || id_inst !== 16'h1100) begin
      n_err++;
      $display("FAIL redir_idle_head: valid=%b pc=%h inst=%h, required 1/0100/1100", id_valid, id_pc, id_inst);
    end
    id_ready = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_redirect_drop();
    bit seen;
    do_reset(3, 1'b0, 1'b1);
    fill_stream(16'h0000, 64);
    repeat (2) @(negedge clk);
    do_redirect(16'h0040);
    n_vec++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0000 || fetch_pc !== 16'h0040 || id_valid !== 1'b0 || state_dbg !== ST_DROP) begin
      n_err++;
      $display("FAIL drop_hold: req=%b addr=%h fetch_pc=%h valid=%b state=%0d, required 1/0000/0040/0/%0d",
               imem_req, imem_addr, fetch_pc, id_valid, state_dbg, ST_DROP);
    end
    repeat (2) @(negedge clk);
    n_vec++;
    if (imem_req !== 1'b0 || occupancy !== 3'd0) begin
      n_err++;
      $display("FAIL drop_gap: req=%b occ=%0d, required 0/0", imem_req, occupancy);
    end
    @(negedge clk);
    n_vec++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0040) begin
      n_err++;
      $display("FAIL drop_reissue: req=%b addr=%h, required 1/0040", imem_req, imem_addr);
    end
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge clk);
      seen = id_valid;
    end
    n_vec++;
    if (!seen || id_pc !== 16'h0040) begin
      n_err++;
      $display("FAIL drop_first: valid=%b pc=%h, required 1/0040", seen, id_pc);
    end
    repeat (12) @(negedge clk);
  endtask

  task automatic test_halt();
    hlt_word_en = 1'b1;
    do_reset(0, 1'b0, 1'b0);
    fill_stream(16'h0000, 64);
    repeat (8) @(negedge clk);
`ifdef IFQ_HLT_STOP_EN
    n_vec++;
    if (occupancy !== 3'd3 || imem_req !== 1'b0 || state_dbg !== ST_HALT || fetch_pc !== 16'h0003) begin
      n_err++;
      $display("FAIL halt_stop: occ=%0d req=%b state=%0d fetch_pc=%h, required 3/0/%0d/0003",
               occupancy, imem_req, state_dbg, fetch_pc, ST_HALT);
    end
    id_ready = 1'b1;
    repeat (6) @(negedge clk);
    n_vec++;
    if (occupancy !== 3'd0 || imem_req !== 1'b0 || pop_cnt == 0) begin
      n_err++;
      $display("FAIL halt_drain: occ=%0d req=%b, required 0/0", occupancy, imem_req);
    end
    do_redirect(16'h0010);
    n_vec++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0010) begin
      n_err++;
      $display("FAIL halt_resume: req=%b addr=%h, required 1/0010", imem_req, imem_addr);
    end
`else
    n_vec++;
    if (occupancy !== 3'd4 || imem_req !== 1'b0 || fetch_pc !== 16'h0004) begin
      n_err++;
      $display("FAIL hlt_ignored: occ=%0d req=%b fetch_pc=%h, required 4/0/0004", occupancy, imem_req, fetch_pc);
    end
    id_ready = 1'b1;
`endif
    repeat (10) @(negedge clk);
    hlt_word_en = 1'b0;
  endtask

  task automatic test_wrap();
    do_reset(0, 1'b0, 1'b1);
    fill_stream(16'h0000, 64);
    repeat (4) @(negedge clk);
    do_redirect(16'hFFFF);
    n_vec++;
    if (imem_req !== 1'b0 || fetch_pc !== 16'hFFFF || id_valid !== 1'b0) begin
      n_err++;
      $display("FAIL wrap_redir_ack: req=%b fetch_pc=%h valid=%b, required 0/FFFF/0", imem_req, fetch_pc, id_valid);
    end
    @(negedge clk);
    n_vec++;
    if (imem_req !== 1'b1 || imem_addr !== 16'hFFFF) begin
      n_err++;
      $display("FAIL wrap_req: req=%b addr=%h, required 1/FFFF", imem_req, imem_addr);
    end
    @(negedge clk);
    n_vec++;
    if (imem_addr !== 16'h0000 || id_pc !== 16'hFFFF || id_inst !== 16'h1FFF) begin
      n_err++;
      $display("FAIL wrap_next: addr=%h pc=%h inst=%h, required 0000/FFFF/1FFF", imem_addr, id_pc, id_inst);
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_random();
    int p0;
    do_reset(0, 1'b1, 1'b1);
    fill_stream(16'h0000, 512);
    p0 = pop_cnt;
    for (int i = 0; i < 600; i++) begin
      id_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) do_redirect(16'($urandom_range(0, 16'hFFFF)));
      else @(negedge clk);
      n_vec++;
      if (occupancy > 3'(DEPTH) || id_valid !== (occupancy != 3'd0)) begin
        n_err++;
        $display("FAIL rand_occ: occ=%0d valid=%b, required occ<=%0d and valid=(occ!=0)", occupancy, id_valid, DEPTH);
      end
    end
    n_vec++;
    if (pop_cnt - p0 < 50) begin
      n_err++;
      $display("FAIL rand_progress: pops=%0d, required >=50", pop_cnt - p0);
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_backpressure();
    test_redirect_idle();
    test_redirect_drop();
    test_halt();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
